// File: rtl/hub75_column_scanner.sv
// HUB75 column scanner: fetches a column pair per address into a line buffer,
// then shifts three binary-coded modulation planes out to a 1:32-scan panel.
module hub75_column_scanner #(
   parameter int SCAN_RATE = 32,
   parameter int NUM_COLS  = 64,
   parameter int NUM_ROWS  = 64,
   parameter int RGB_RES   = 9,
   parameter int BASE_OE   = 16
) (
   input  logic                                        clk_in,
   input  logic                                        rst_n_in,
   input  logic                                        enable_in,
   output logic [$clog2(SCAN_RATE)-1:0]                column_index1,
   output logic [$clog2(SCAN_RATE):0]                  column_index2,
   input  logic [1:0][NUM_ROWS-1:0][RGB_RES-1:0]       columns_in,
   output logic [2:0]                                  rgb1_out,
   output logic [2:0]                                  rgb2_out,
   output logic [$clog2(SCAN_RATE)-1:0]                addr_out,
   output logic                                        hub_clk_out,
   output logic                                        hub_lat_out,
   output logic                                        hub_oe_out,
   output logic                                        frame_done_out
);

   // state   | meaning
   // IDLE    | blanked, waiting for enable_in
   // FETCH   | k=0..31: request column pair k / 32+k, capture rows a and a+32
   // SHIFT   | 2 cycles per pixel, 64 pixels of the current plane
   // LATCH   | 1-cycle latch pulse, still blanked
   // DISPLAY | oe low for BASE_OE<<plane cycles
   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_SHIFT,
      S_LATCH,
      S_DISPLAY
   } state_t;

   localparam int AW  = $clog2(SCAN_RATE);
   localparam int CW  = $clog2(NUM_COLS);
   localparam int RW  = $clog2(NUM_ROWS);
   localparam int SW  = CW + 1;
   localparam int OEW = $clog2(BASE_OE*4) + 1;
   localparam int CH  = RGB_RES / 3;
   localparam int IW  = $clog2(RGB_RES);

   localparam logic [AW-1:0]  K_LAST     = AW'(SCAN_RATE-1);
   localparam logic [AW:0]    C2_BASE    = (AW+1)'(SCAN_RATE);
   localparam logic [SW-1:0]  SHIFT_LAST = SW'(2*NUM_COLS-1);
   localparam logic [1:0]     PLANE_LAST = 2'd2;
   localparam logic [OEW-1:0] OE_BASE    = OEW'(BASE_OE);

   state_t               r_state;
   state_t               w_state_nxt;
   logic [AW-1:0]        r_k;
   logic [SW-1:0]        r_cnt;
   logic [1:0]           r_plane;
   logic [OEW-1:0]       r_oe;
   logic [AW-1:0]        r_addr;
   logic                 r_frame_done;
   logic [RGB_RES-1:0]   r_top [NUM_COLS];
   logic [RGB_RES-1:0]   r_bot [NUM_COLS];

   logic                 w_disp_end;
   logic                 w_plane_last;
   logic [CW-1:0]        w_pix;
   logic [CW-1:0]        w_lo_idx;
   logic [CW-1:0]        w_hi_idx;
   logic [RW-1:0]        w_row_top;
   logic [RW-1:0]        w_row_bot;
   logic [RGB_RES-1:0]   w_top_pix;
   logic [RGB_RES-1:0]   w_bot_pix;
   logic [IW-1:0]        w_ib;
   logic [IW-1:0]        w_ig;
   logic [IW-1:0]        w_ir;

   assign w_disp_end   = (r_state == S_DISPLAY) && (r_oe == '0);
   assign w_plane_last = (r_plane == PLANE_LAST);
   assign w_pix        = r_cnt[SW-1:1];
   assign w_lo_idx     = CW'(r_k);
   assign w_hi_idx     = CW'(r_k) + CW'(SCAN_RATE);
   assign w_row_top    = RW'(r_addr);
   assign w_row_bot    = RW'(r_addr) + RW'(SCAN_RATE);
   assign w_top_pix    = r_top[w_pix];
   assign w_bot_pix    = r_bot[w_pix];
   assign w_ib         = IW'(r_plane);
   assign w_ig         = IW'(CH) + IW'(r_plane);
   assign w_ir         = IW'(2*CH) + IW'(r_plane);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (enable_in) w_state_nxt = S_FETCH;
         S_FETCH:   if (r_k == K_LAST) w_state_nxt = S_SHIFT;
         S_SHIFT:   if (r_cnt == SHIFT_LAST) w_state_nxt = S_LATCH;
         S_LATCH:   w_state_nxt = S_DISPLAY;
         S_DISPLAY: begin
            if (w_disp_end) begin
               if (!w_plane_last)  w_state_nxt = S_SHIFT;
               else if (enable_in) w_state_nxt = S_FETCH;
               else                w_state_nxt = S_IDLE;
            end
         end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      column_index1 = '0;
      column_index2 = '0;
      rgb1_out      = '0;
      rgb2_out      = '0;
      hub_clk_out   = 1'b0;
      hub_lat_out   = 1'b0;
      hub_oe_out    = 1'b1;
      case (r_state)
         S_FETCH: begin
            column_index1 = r_k;
            column_index2 = C2_BASE + {1'b0, r_k};
         end
         S_SHIFT: begin
            hub_clk_out = r_cnt[0];
            rgb1_out    = {w_top_pix[w_ir], w_top_pix[w_ig], w_top_pix[w_ib]};
            rgb2_out    = {w_bot_pix[w_ir], w_bot_pix[w_ig], w_bot_pix[w_ib]};
         end
         S_LATCH:   hub_lat_out = 1'b1;
         S_DISPLAY: hub_oe_out  = 1'b0;
         default: ;
      endcase
   end

   assign addr_out       = r_addr;
   assign frame_done_out = r_frame_done;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state      <= S_IDLE;
         r_k          <= '0;
         r_cnt        <= '0;
         r_plane      <= '0;
         r_oe         <= '0;
         r_addr       <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         if ((r_state == S_FETCH) && (r_k != K_LAST)) r_k <= r_k + AW'(1);
         else                                         r_k <= '0;

         if (r_state == S_SHIFT) r_cnt <= r_cnt + SW'(1);
         else                    r_cnt <= '0;

         if (r_state == S_FETCH)               r_plane <= '0;
         else if (w_disp_end && !w_plane_last) r_plane <= r_plane + 2'd1;

         // down-counter loaded with the plane's weight minus one; DISPLAY ends at zero
         if (r_state == S_LATCH)
            r_oe <= (OE_BASE << r_plane) - OEW'(1);
         else if ((r_state == S_DISPLAY) && (r_oe != '0))
            r_oe <= r_oe - OEW'(1);

         if (w_disp_end && w_plane_last) r_addr <= r_addr + AW'(1);

         r_frame_done <= w_disp_end && w_plane_last && (r_addr == K_LAST);
      end
   end

   // line buffer is plain storage; every entry is rewritten in FETCH before use
   always_ff @(posedge clk_in) begin
      if (r_state == S_FETCH) begin
         r_top[w_lo_idx] <= columns_in[0][w_row_top];
         r_top[w_hi_idx] <= columns_in[1][w_row_top];
         r_bot[w_lo_idx] <= columns_in[0][w_row_bot];
         r_bot[w_hi_idx] <= columns_in[1][w_row_bot];
      end
   end

endmodule

// File: tb/tb_hub75_column_scanner.sv
// Scoreboard bench for hub75_column_scanner: a row-level timing/pixel model
// queues expected panel events; a negedge monitor pops and compares them.
module tb_hub75_column_scanner;

   logic                   clk_in = 1'b0;
   logic                   rst_n_in;
   logic                   enable_in;
   logic [4:0]             column_index1;
   logic [5:0]             column_index2;
   logic [1:0][63:0][8:0]  columns_in;
   logic [2:0]             rgb1_out;
   logic [2:0]             rgb2_out;
   logic [4:0]             addr_out;
   logic                   hub_clk_out;
   logic                   hub_lat_out;
   logic                   hub_oe_out;
   logic                   frame_done_out;

   hub75_column_scanner dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .enable_in     (enable_in),
      .column_index1 (column_index1),
      .column_index2 (column_index2),
      .columns_in    (columns_in),
      .rgb1_out      (rgb1_out),
      .rgb2_out      (rgb2_out),
      .addr_out      (addr_out),
      .hub_clk_out   (hub_clk_out),
      .hub_lat_out   (hub_lat_out),
      .hub_oe_out    (hub_oe_out),
      .frame_done_out(frame_done_out)
   );

   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   // source image: img[column][row]
   logic [8:0] img [64][64];

   always_comb begin
      columns_in = '0;
      for (int r = 0; r < 64; r++) begin
         columns_in[0][r] = img[int'(column_index1)][r];
         columns_in[1][r] = img[int'(column_index2)][r];
      end
   end

   localparam int K_FETCH = 0;
   localparam int K_PIX   = 1;
   localparam int K_LAT   = 2;
   localparam int K_OE    = 3;
   localparam int K_FRAME = 4;

   typedef struct {
      int kind;
      int cyc;
      int v1;
      int v2;
   } ev_t;

   ev_t exp_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  R;
   int  a_model;

   task automatic check(input string name, input int act, input int exp_v);
      n_checks++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   task automatic set_image(input int mode);
      for (int c = 0; c < 64; c++)
         for (int r = 0; r < 64; r++)
            case (mode)
               1:       img[c][r] = 9'h1FF;
               2:       img[c][r] = 9'h000;
               default: img[c][r] = 9'($urandom_range(0, 511));
            endcase
      if (mode == 2) img[5][40] = 9'b101_010_001;
   endtask

   // channel order {R,G,B}; R=[8:6], G=[5:3], B=[2:0]; plane p takes bit p of each
   function automatic int plane_rgb(input int v, input int p);
      return (((v >> (6 + p)) & 1) << 2) | (((v >> (3 + p)) & 1) << 1) | ((v >> p) & 1);
   endfunction

   task automatic push_ev(input int kind, input int c, input int v1, input int v2);
      ev_t e;
      e.kind = kind;
      e.cyc  = c;
      e.v1   = v1;
      e.v2   = v2;
      exp_q.push_back(e);
   endtask

   // one full row starting (first FETCH cycle) at r0 for address a
   task automatic push_row(input int r0, input int a);
      int s;
      int e1;
      int e2;
      push_ev(K_FETCH, r0, a, 0);
      s = r0 + 32;
      for (int p = 0; p < 3; p++) begin
         for (int c = 0; c < 64; c++) begin
            e1 = plane_rgb(int'(img[c][a]), p);
            e2 = plane_rgb(int'(img[c][a + 32]), p);
            push_ev(K_PIX, s + 2 * c + 1, e1 * 9, e2 * 9);
         end
         push_ev(K_LAT, s + 128, 2, a);
         push_ev(K_OE, s + 129, 16 << p, 0);
         s = s + 129 + (16 << p);
      end
      if (a == 31) push_ev(K_FRAME, s, 0, 0);
   endtask

   task automatic pop_check(input string name, input int kind, input int c, input int v1, input int v2);
      ev_t e;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: got event at cycle %0d v1=%0d v2=%0d, required no event", name, c, v1, v2);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != kind || e.cyc != c || e.v1 != v1 || e.v2 != v2) begin
            n_fail++;
            $display("FAIL %s: got kind=%0d cyc=%0d v1=%0d v2=%0d, required kind=%0d cyc=%0d v1=%0d v2=%0d",
                     name, kind, c, v1, v2, e.kind, e.cyc, e.v1, e.v2);
         end
      end
   endtask

   // monitor
   logic       prev_oe = 1'b1;
   int         run_len = 0;
   logic [2:0] prev_rgb1 = '0;
   logic [2:0] prev_rgb2 = '0;

   always @(negedge clk_in) begin
      if (!rst_n_in) begin
         prev_oe   = 1'b1;
         run_len   = 0;
         prev_rgb1 = '0;
         prev_rgb2 = '0;
      end else begin
         if (hub_oe_out == 1'b0) run_len++;
         else if (prev_oe == 1'b0) begin
            pop_check("oe_run", K_OE, cyc - run_len, run_len, 0);
            run_len = 0;
         end
         if (frame_done_out) pop_check("frame_done", K_FRAME, cyc, 0, 0);
         if (column_index2 == 6'd32 && column_index1 == 5'd0)
            pop_check("fetch_start", K_FETCH, cyc, int'(addr_out), 0);
         if (hub_lat_out)
            pop_check("latch", K_LAT, cyc, int'(hub_oe_out) * 2 + int'(hub_clk_out), int'(addr_out));
         if (hub_clk_out)
            pop_check("pixel", K_PIX, cyc, int'(prev_rgb1) * 8 + int'(rgb1_out),
                      int'(prev_rgb2) * 8 + int'(rgb2_out));
         prev_oe   = hub_oe_out;
         prev_rgb1 = rgb1_out;
         prev_rgb2 = rgb2_out;
      end
   end

   // queue the row, then at mid-row (fetch long done) update image and enable
   task automatic do_row(input int mode, input bit cont);
      push_row(R, a_model);
      while (cyc < R + 300) @(negedge clk_in);
      if (mode != 0) set_image(mode);
      enable_in = cont;
   endtask

   initial begin
      int  mode;
      bit  cont;
      bit  running;
      int  gap;
      int  rows_left;

      rst_n_in  = 1'b0;
      enable_in = 1'b1;
      set_image(1);
      repeat (4) @(negedge clk_in);
      check("rst_oe", int'(hub_oe_out), 1);
      check("rst_lat", int'(hub_lat_out), 0);
      check("rst_clk", int'(hub_clk_out), 0);
      check("rst_rgb1", int'(rgb1_out), 0);
      check("rst_rgb2", int'(rgb2_out), 0);
      check("rst_idx1", int'(column_index1), 0);
      check("rst_idx2", int'(column_index2), 0);
      check("rst_addr", int'(addr_out), 0);
      check("rst_frame", int'(frame_done_out), 0);
      #1 rst_n_in = 1'b1;
      R       = cyc + 1;
      a_model = 0;

      // free run: all-ones rows, sparse pixel, random rows, full frame wrap, stop after row 5
      for (int i = 0; i < 38; i++) begin
         mode = (i == 1) ? 2 : ((i == 9 || i == 20 || i == 30) ? 3 : 0);
         cont = (i != 37);
         do_row(mode, cont);
         a_model = (a_model + 1) % 32;
         if (cont) R = R + 531;
      end
      while (cyc < R + 531 + 10) @(negedge clk_in);
      check("idle_addr", int'(addr_out), a_model);
      check("idle_oe", int'(hub_oe_out), 1);

      // random enable drops with random idle gaps
      running   = 1'b0;
      rows_left = 6;
      while (rows_left > 0) begin
         if (!running) begin
            gap = $urandom_range(1, 40);
            while (cyc < R + 531 + gap) @(negedge clk_in);
            enable_in = 1'b1;
            R = cyc + 1;
         end
         cont = (rows_left == 1) ? 1'b0 : 1'($urandom_range(0, 1));
         do_row(3, cont);
         a_model = (a_model + 1) % 32;
         rows_left--;
         if (cont) R = R + 531;
         running = cont;
      end

      // reset in the middle of plane-1 DISPLAY
      while (cyc < R + 531 + 5) @(negedge clk_in);
      enable_in = 1'b1;
      R = cyc + 1;
      push_row(R, a_model);
      while (cyc < R + 310) @(negedge clk_in);
      check("pre_rst_oe", int'(hub_oe_out), 0);
      #2 rst_n_in = 1'b0;
      exp_q.delete();
      #1;
      check("midrst_oe", int'(hub_oe_out), 1);
      check("midrst_lat", int'(hub_lat_out), 0);
      check("midrst_addr", int'(addr_out), 0);
      check("midrst_clk", int'(hub_clk_out), 0);
      repeat (3) @(negedge clk_in);
      #1 rst_n_in = 1'b1;
      R       = cyc + 1;
      a_model = 0;
      do_row(3, 1'b1);
      a_model = (a_model + 1) % 32;
      R = R + 531;
      do_row(0, 1'b0);
      a_model = (a_model + 1) % 32;
      while (cyc < R + 531 + 20) @(negedge clk_in);
      check("queue_drained", exp_q.size(), 0);
      check("final_addr", int'(addr_out), a_model);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
